// File: rtl/ibex_fetch_realigner.sv
// ibex_fetch_realigner: buffers fetch words and re-aligns the halfword stream into
// whole 16/32-bit instructions, including ones straddling two fetch words.
module ibex_fetch_realigner #(
    parameter int unsigned DEPTH = 2,
    parameter bit          RV32C = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q, rd_nx;
    logic [CW-1:0] cnt_q;
    logic [31:0]   pc_q;
    logic          off_q;
    logic [32:0]   head;
    logic [15:0]   half;
    logic          comp, strad, valid, err, push, pop, accept;
    logic [31:0]   rdata;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_nx = inc(rd_q);
        head  = mem_q[rd_q];
        half  = off_q ? head[31:16] : head[15:0];
        comp  = RV32C && (half[1:0] != 2'b11);
        strad = off_q && !comp;
        // a straddler needs the following word unless the head already reports an error
        valid = (cnt_q != '0) && (head[32] || !strad || cnt_q > CW'(1));
        err   = head[32] || (strad && mem_q[rd_nx][32]);
        rdata = err ? '0 : comp ? {16'h0, half} : strad ? {mem_q[rd_nx][15:0], half} : head[31:0];
    end

    assign in_ready_o          = cnt_q != FULL;
    assign push                = in_valid_i && in_ready_o && !clear_i;
    assign accept              = valid && out_ready_i && !clear_i;
    assign pop                 = accept && (head[32] || !comp || off_q);
    assign out_valid_o         = valid;
    assign out_rdata_o         = valid ? rdata : '0;
    assign out_addr_o          = valid ? pc_q : '0;
    assign out_is_compressed_o = valid && !err && comp;
    assign out_err_o           = valid && err;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= {in_err_i, in_rdata_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            pc_q  <= '0;
            off_q <= 1'b0;
        end else if (clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            pc_q  <= clear_addr_i & (RV32C ? ~32'd1 : ~32'd3);
            off_q <= RV32C && clear_addr_i[1];
        end else begin
            if (push) wr_q <= inc(wr_q);
            if (pop) rd_q <= rd_nx;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (accept) begin
                off_q <= !head[32] && (comp ? !off_q : off_q);
                pc_q  <= pc_q + (head[32] ? (off_q ? 32'd2 : 32'd4) : comp ? 32'd2 : 32'd4);
            end
        end
    end
endmodule

// File: tb/tb_ibex_fetch_realigner.sv
// tb_ibex_fetch_realigner: directed and random checks against a halfword-stream model
// of the realigner (RV32C instance) plus directed checks of an RV32C=0 instance.
module tb_ibex_fetch_realigner;
    localparam int DEPTH = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 0, iv = 0, ierr = 0, ordy = 0;
    logic [31:0] caddr = 0, idata = 0;
    logic        ir, ov, oc, oe;
    logic [31:0] od, oa;

    logic        clr2 = 0, iv2 = 0, ierr2 = 0, ordy2 = 0;
    logic [31:0] caddr2 = 0, idata2 = 0;
    logic        ir2, ov2, oc2, oe2;
    logic [31:0] od2, oa2;

    ibex_fetch_realigner #(.DEPTH(DEPTH), .RV32C(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .clear_addr_i(caddr),
        .in_valid_i(iv), .in_ready_o(ir), .in_rdata_i(idata), .in_err_i(ierr),
        .out_valid_o(ov), .out_ready_i(ordy), .out_rdata_o(od), .out_addr_o(oa),
        .out_is_compressed_o(oc), .out_err_o(oe)
    );

    ibex_fetch_realigner #(.DEPTH(2), .RV32C(1'b0)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr2), .clear_addr_i(caddr2),
        .in_valid_i(iv2), .in_ready_o(ir2), .in_rdata_i(idata2), .in_err_i(ierr2),
        .out_valid_o(ov2), .out_ready_i(ordy2), .out_rdata_o(od2), .out_addr_o(oa2),
        .out_is_compressed_o(oc2), .out_err_o(oe2)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // model: the buffered instruction stream as halfwords, each tagged with its word's
    // error flag and whether it is the upper (last) halfword of its fetch word
    typedef struct {
        logic [15:0] d;
        bit          e;
        bit          last;
    } hw_t;

    hw_t         q[$];
    logic [31:0] mpc = 0;
    bit          skip = 0;
    logic        e_v, e_c, e_e, e_r;
    logic [31:0] e_d;
    int          e_n;

    task automatic model_eval();
        int w = 0;
        e_v = 0; e_c = 0; e_e = 0; e_d = 0; e_n = 0;
        foreach (q[i]) w += int'(q[i].last);
        e_r = w < DEPTH;
        if (q.size() > 0) begin
            if (q[0].e) begin
                e_v = 1; e_e = 1; e_n = q[0].last ? 1 : 2;
            end else if (q[0].d[1:0] != 2'b11) begin
                e_v = 1; e_c = 1; e_d = {16'h0, q[0].d}; e_n = 1;
            end else if (q.size() > 1) begin
                e_v = 1; e_e = q[1].e; e_d = q[1].e ? 32'h0 : {q[1].d, q[0].d}; e_n = 2;
            end
        end
    endtask

    task automatic cycle(input bit c, input logic [31:0] a, input bit v,
                         input logic [31:0] d, input bit e, input bit r);
        model_eval();
        check("valid", ov, e_v);
        check("in_ready", ir, e_r);
        check("rdata", od, e_d);
        check("addr", oa, e_v ? mpc : 32'h0);
        check("compressed", oc, e_c);
        check("err", oe, e_e);
        clr = c; caddr = a; iv = v; idata = d; ierr = e; ordy = r;
        if (c) begin
            q.delete();
            mpc  = {a[31:1], 1'b0};
            skip = a[1];
        end else begin
            if (e_v && r) begin
                for (int i = 0; i < e_n; i++) void'(q.pop_front());
                mpc += 32'(2 * e_n);
            end
            if (v && e_r) begin
                if (!skip) q.push_back('{d[15:0], e, 1'b0});
                q.push_back('{d[31:16], e, 1'b1});
                skip = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rhw();
        logic [15:0] x = 16'($urandom);
        if ($urandom_range(1) == 1) x[1:0] = 2'b11;
        return x;
    endfunction

    task automatic random_run(input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = $urandom;
            if ($urandom_range(3) == 0) a[31:4] = '1;
            cycle($urandom_range(29) == 0, a, $urandom_range(9) < 7, {rhw(), rhw()},
                  $urandom_range(15) == 0, $urandom_range(9) < 6);
        end
    endtask

    initial begin
        #2;
        check("reset valid", ov, 0);
        check("reset in_ready", ir, 1);
        check("reset rdata", od, 0);
        check("reset addr", oa, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // two compressed halves of one word
        cycle(1, 32'h100, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0001_0001, 0, 0);
        check("c16 first rdata", od, 32'h1);
        check("c16 first addr", oa, 32'h100);
        cycle(0, 0, 0, 0, 0, 1);
        check("c16 second addr", oa, 32'h102);
        check("c16 second comp", oc, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("c16 drained", ov, 0);

        // straddling 32-bit instruction
        cycle(1, 32'h202, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h00B3_0001, 0, 0);
        check("strad wait", ov, 0);
        cycle(0, 0, 1, 32'h0000_0000, 0, 0);
        check("strad rdata", od, 32'h0000_00B3);
        check("strad addr", oa, 32'h202);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // full FIFO back-pressure
        cycle(1, 32'h0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0013, 0, 0);
        cycle(0, 0, 1, 32'h0000_0013, 0, 0);
        check("full in_ready", ir, 0);
        cycle(0, 0, 0, 0, 0, 1);
        check("after pop in_ready", ir, 1);

        // clear while output valid and a push is offered
        cycle(1, 32'h500, 1, 32'hDEAD_BEEF, 0, 1);
        check("clear valid", ov, 0);
        check("clear in_ready", ir, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("clear dropped push", ov, 0);

        // straddler whose following word has a bus error
        cycle(1, 32'h402, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0003_0000, 0, 0);
        cycle(0, 0, 1, 32'h1234_5678, 1, 0);
        check("nexterr err", oe, 1);
        check("nexterr addr", oa, 32'h402);
        check("nexterr rdata", od, 0);
        cycle(0, 0, 0, 0, 0, 1);
        check("nexterr head only", ir, 1);
        check("nexterr second addr", oa, 32'h406);
        cycle(0, 0, 0, 0, 0, 1);

        random_run(3000);

        // asynchronous reset mid-operation
        clr = 0; iv = 0; ordy = 0; ierr = 0;
        cycle(0, 0, 1, 32'h0000_0013, 0, 0);
        clr = 0; iv = 0; ordy = 0;
        #2 rst_n = 0;
        #1;
        check("async rst valid", ov, 0);
        check("async rst in_ready", ir, 1);
        check("async rst addr", oa, 0);
        q.delete(); mpc = 0; skip = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        random_run(1500);

        // RV32C=0 instance
        clr = 0; iv = 0; ordy = 0;
        clr2 = 1; caddr2 = 32'h302;
        @(posedge clk); #1;
        clr2 = 0; iv2 = 1; idata2 = 32'h0000_0001;
        @(posedge clk); #1;
        iv2 = 0;
        check("rv32 rdata", od2, 32'h1);
        check("rv32 addr", oa2, 32'h300);
        check("rv32 comp", oc2, 0);
        iv2 = 1; idata2 = 32'h0001_0001; ordy2 = 1;
        @(posedge clk); #1;
        iv2 = 0;
        check("rv32 whole word", od2, 32'h0001_0001);
        check("rv32 addr2", oa2, 32'h304);
        @(posedge clk); #1;
        ordy2 = 0;
        check("rv32 drained", ov2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
